uart_cmd_frame_gen: RTL
=======================

Name: uart_cmd_frame_gen

Overview:
Host-side command framer upstream of the system's UART receive path. It accepts one decoded command per handshake and serialises it into the byte frame that the system controller decodes: register-file write, register-file read, ALU with operands, or ALU without operands. It emits one byte at a time over a valid/ready stream to a UART transmitter, inserts a programmable idle gap between frames and counts completed frames. One clock; reset is synchronous and active-high.

Parameters:
DATA_WIDTH, 8, width of every frame byte and data/operand field
ADDR_BITS, 4, register-file address width; zero-extended to DATA_WIDTH in the frame
FUN_WIDTH, 4, ALU function code width; zero-extended to DATA_WIDTH in the frame
GAP_WIDTH, 8, width of the inter-frame gap counter
CNT_WIDTH, 16, width of the completed-frame counter

Ports:
CLK  in  1  single clock; all logic rises on posedge CLK
RST  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  block can accept a command
CMD_TYPE  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU no operands
CMD_ADDR  in  ADDR_BITS  register address (types 0,1)
CMD_WDATA  in  DATA_WIDTH  write data (type 0)
CMD_OPA  in  DATA_WIDTH  operand A (type 2)
CMD_OPB  in  DATA_WIDTH  operand B (type 2)
CMD_FUN  in  FUN_WIDTH  ALU function (types 2,3)
GAP_CYCLES  in  GAP_WIDTH  idle cycles after each frame; 0 = none
TX_DATA  out  DATA_WIDTH  current frame byte
TX_VALID  out  1  TX_DATA valid
TX_READY  in  1  downstream accepts byte
BUSY  out  1  frame in flight or gap running
FRAME_DONE  out  1  one-cycle pulse on last byte accepted
FRAME_CNT  out  CNT_WIDTH  frames completed, wraps

Behaviour:
- Reset (RST=1 at posedge): state IDLE; CMD_READY=1, TX_VALID=0, TX_DATA=0, BUSY=0, FRAME_DONE=0, FRAME_CNT=0. RST overrides every other input. Reset mid-frame abandons the frame; no further bytes of it are emitted.
- Frame formats (bytes in order):
  type 0: 0xAA, {0,ADDR}, WDATA (3 bytes)
  type 1: 0xBB, {0,ADDR} (2 bytes)
  type 2: 0xCC, OPA, OPB, {0,FUN} (4 bytes)
  type 3: 0xDD, {0,FUN} (2 bytes)
- All command fields and GAP_CYCLES are captured into registers at acceptance; later changes on inputs have no effect on the frame in flight.
- States: IDLE, SEND, GAP.
  IDLE: CMD_READY=1. On CMD_VALID&CMD_READY: capture, go SEND; next cycle TX_VALID=1, TX_DATA=opcode, BUSY=1, CMD_READY=0.
  SEND: byte index 0..len-1. Byte transfers when TX_VALID&TX_READY; index increments, TX_DATA updates next cycle, TX_VALID stays 1. With TX_READY=0, TX_DATA and TX_VALID hold stable indefinitely. On transfer of the last byte: TX_VALID=0 next cycle, FRAME_DONE=1 for exactly one cycle, FRAME_CNT+1 (wrap from all-ones to 0); go GAP if captured gap != 0, else IDLE.
  GAP: counts captured gap cycles with TX_VALID=0, BUSY=1, CMD_READY=0; then IDLE.
- Latency: command accepted at edge N -> first byte valid after edge N; with TX_READY held 1, a k-byte frame occupies k cycles of TX_VALID; CMD_READY returns 1 in the cycle after the final transfer when gap=0, else after the gap expires.
- CMD_READY is registered, not combinationally dependent on CMD_VALID. CMD_VALID while CMD_READY=0 is ignored (no capture, no error).
- No back-to-back frames without passing through IDLE for at least one cycle.

Test Plan:
- Reset then type 0, ADDR=5, WDATA=0x3C, GAP=0, TX_READY=1 -> bytes 0xAA,0x05,0x3C on consecutive cycles; FRAME_DONE one pulse; FRAME_CNT=1; CMD_READY=1 next cycle.
- Type 2, OPA=0x12, OPB=0x34, FUN=1, TX_READY toggling 1/0 -> bytes 0xCC,0x12,0x34,0x01 in order, each held stable while TX_READY=0, none duplicated or dropped.
- Type 1 ADDR=0xF then type 3 FUN=0xA with GAP=3 -> 0xBB,0x0F; three idle cycles with BUSY=1, CMD_READY=0; then 0xDD,0x0A.
- Change CMD_* inputs mid-frame -> emitted bytes equal captured values.
- RST asserted while second byte of a type 2 frame pending -> next cycle TX_VALID=0, FRAME_CNT=0, CMD_READY=1; no remaining bytes emitted.
- Preload-free wrap: issue 2^CNT_WIDTH frames (or CNT_WIDTH=2 build, 5 frames) -> FRAME_CNT wraps to 0 then 1.

Source files
------------

// File: rtl/uart_cmd_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_frame_gen
// Description : Serialises one decoded host command per handshake into the
//               byte frame the system controller decodes, streams it out one
//               byte at a time over valid/ready, inserts a programmable idle
//               gap after each frame and counts completed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int GAP_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [ADDR_BITS-1:0]  CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    input  logic [DATA_WIDTH-1:0] CMD_OPA,
    input  logic [DATA_WIDTH-1:0] CMD_OPB,
    input  logic [FUN_WIDTH-1:0]  CMD_FUN,
    input  logic [GAP_WIDTH-1:0]  GAP_CYCLES,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT
);

    // Frame opcode bytes, one per command type
    localparam logic [DATA_WIDTH-1:0] OP_RF_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RF_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;

    // Command captured at acceptance; the frame in flight uses only these
    logic [1:0]              type_q;
    logic [ADDR_BITS-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   opa_q;
    logic [DATA_WIDTH-1:0]   opb_q;
    logic [FUN_WIDTH-1:0]    fun_q;
    logic [GAP_WIDTH-1:0]    gap_q;

    logic [1:0]              byte_idx;
    logic [GAP_WIDTH-1:0]    gap_cnt;
    logic                    frame_done_q;
    logic [CNT_WIDTH-1:0]    frame_cnt_q;

    logic                    accept;
    logic                    xfer;
    logic                    last_xfer;
    logic [1:0]              last_idx;
    logic [DATA_WIDTH-1:0]   frame_byte;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, byte selection and state-derived outputs
    always_comb begin
        state_next = state;
        last_idx   = 2'd1;
        frame_byte = '0;
        CMD_READY  = 1'b0;
        TX_VALID   = 1'b0;
        TX_DATA    = '0;
        BUSY       = 1'b0;

        case (type_q)
            2'd0: begin
                last_idx = 2'd2;
                case (byte_idx)
                    2'd0:    frame_byte = OP_RF_WR;
                    2'd1:    frame_byte = DATA_WIDTH'(addr_q);
                    default: frame_byte = wdata_q;
                endcase
            end
            2'd1: begin
                last_idx   = 2'd1;
                frame_byte = (byte_idx == 2'd0) ? OP_RF_RD : DATA_WIDTH'(addr_q);
            end
            2'd2: begin
                last_idx = 2'd3;
                case (byte_idx)
                    2'd0:    frame_byte = OP_ALU_OP;
                    2'd1:    frame_byte = opa_q;
                    2'd2:    frame_byte = opb_q;
                    default: frame_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: begin
                last_idx   = 2'd1;
                frame_byte = (byte_idx == 2'd0) ? OP_ALU_NO : DATA_WIDTH'(fun_q);
            end
        endcase

        accept    = (state == ST_IDLE) && CMD_VALID;
        xfer      = (state == ST_SEND) && TX_READY;
        last_xfer = xfer && (byte_idx == last_idx);

        case (state)
            ST_IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                TX_VALID = 1'b1;
                TX_DATA  = frame_byte;
                BUSY     = 1'b1;
                if (last_xfer) begin
                    state_next = (gap_q != '0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                BUSY = 1'b1;
                if (gap_cnt == GAP_WIDTH'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture command fields on acceptance (datapath, no reset needed)
    always_ff @(posedge CLK) begin
        if (!RST && accept) begin
            type_q  <= CMD_TYPE;
            addr_q  <= CMD_ADDR;
            wdata_q <= CMD_WDATA;
            opa_q   <= CMD_OPA;
            opb_q   <= CMD_OPB;
            fun_q   <= CMD_FUN;
            gap_q   <= GAP_CYCLES;
        end
    end

    // Byte index, gap countdown, done pulse and completed-frame counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_idx     <= 2'd0;
            gap_cnt      <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= last_xfer;
            if (accept || last_xfer) begin
                byte_idx <= 2'd0;
            end else if (xfer) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (last_xfer) begin
                gap_cnt     <= gap_q;
                frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end

    assign FRAME_DONE = frame_done_q;
    assign FRAME_CNT  = frame_cnt_q;

endmodule
`default_nettype wire
